multiword_add_seq: RTL and testbench

//  Multi-cycle add/subtract sequencer. It time-shares one 8-bit lookahead adder slice across the words of a WIDTH-bit operand pair.
//  It processes one slice per cycle, LSB first, and registers the carry between slices.
//  It sits between the operand/issue logic and the multiply/divide datapath, with valid/ready handshakes on both sides.

---
 rtl/multiword_add_seq_pkg.sv | 20 ++
 rtl/multiword_add_seq_if.sv | 48 ++++
 rtl/multiword_add_seq_add8_slice.sv | 53 +++++
 rtl/multiword_add_seq.sv | 128 ++++++++++++
 tb/tb_multiword_add_seq.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multiword_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_pkg
// Description : Shared definitions for the multi-word add/subtract sequencer:
//               slice width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

  // Width of the shared lookahead adder slice.
  localparam int SLICE_W = 8;

  // FSM state encoding (explicit width, legacy-compatible constants).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/multiword_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_seq_if
// Description : Operand-request / result handshake bundle of the multi-word
//               add/subtract sequencer.
//               master : issue side + result consumer (drives in_valid, a, b,
//                        sub, out_ready)
//               slave  : the sequencer (drives in_ready, out_valid, result,
//                        carry_out, overflow[, zero])
//               Optional: ZERO_FLAG_EN adds the zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiword_add_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
`ifdef ZERO_FLAG_EN
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
`endif
endinterface
`default_nettype wire

// File: rtl/multiword_add_seq_add8_slice.sv
`default_nettype none
// ============================================================================
// Module      : add8_slice
// Description : Combinational 8-bit carry-lookahead adder slice.
//               Ports: a, b (8b), cin -> s (8b), cout.
//               Every carry, including cout, is a flat sum of products of
//               generate/propagate terms and cin, so cout depends on cin
//               (needed by the cross-slice carry chain in the sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
module add8_slice
  import add_seq_pkg::*;
(
  input  wire logic [SLICE_W-1:0] a,
  input  wire logic [SLICE_W-1:0] b,
  input  wire logic               cin,
  output logic      [SLICE_W-1:0] s,
  output logic                    cout
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;
  logic               w_term;
  logic               w_acc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]cin
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_acc  = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      w_term = cin;
      for (int j = 0; j <= i; j++) w_term = w_term & w_p[j];
      w_acc = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) w_term = w_term & w_p[k];
        w_acc = w_acc | w_term;
      end
      w_c[i+1] = w_acc;
    end
  end

  assign s    = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_seq
// Description : Multi-cycle add/subtract sequencer. One 8-bit lookahead slice
//               is time-shared across the WIDTH/SLICE words of the operands,
//               LSB word first, with the carry registered between words.
//               Ports: clock, reset (sync, active-high), bus (slave modport of
//               multiword_add_seq_if: in_valid/in_ready, a, b, sub,
//               out_valid/out_ready, result, carry_out, overflow[, zero]).
//               Optional: ZERO_FLAG_EN adds the registered zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_W   // must equal the slice adder width
) (
  input  wire logic          clock,
  input  wire logic          reset,
  multiword_add_seq_if.slave bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSL - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;      // already inverted for subtract
  logic             r_carry;    // carry between slices
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_s;
  logic             w_cout;
  logic             w_last;
  logic             w_ovf;

  // Part-select mux feeds the current word to the single shared slice.
  assign w_sa   = r_opa[int'(r_cnt)*SLICE +: SLICE];
  assign w_sb   = r_opb[int'(r_cnt)*SLICE +: SLICE];
  assign w_last = (r_cnt == LAST_CNT);

  // Signed overflow: operands (after inversion) agree in sign but the top
  // slice's sum bit differs from it.
  assign w_ovf = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                 (w_s[SLICE-1] != r_opa[WIDTH-1]);

  add8_slice u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;   // +1 completes the two's complement
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result[int'(r_cnt)*SLICE +: SLICE] <= w_s;
          r_carry <= w_cout;
          if (w_last) begin
            r_carry_out <= w_cout;
            r_overflow  <= w_ovf;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;

`ifdef ZERO_FLAG_EN
  logic r_zacc;   // OR of all slice sums produced so far
  logic r_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_zacc <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == ST_IDLE && bus.in_valid) begin
      r_zacc <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_zacc <= r_zacc | (|w_s);
      if (w_last) r_zero <= ~(r_zacc | (|w_s));
    end
  end

  assign bus.zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_add_seq
// Description : Self-checking bench for multiword_add_seq (WIDTH=32).
//               Directed vectors with hand-computed results; inputs are
//               driven and outputs sampled on the falling clock edge.
//               Optional: ZERO_FLAG_EN also checks the zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  multiword_add_seq_if #(.WIDTH(32)) bus ();

  multiword_add_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one operation from IDLE (called on a falling edge) and wait for
  // out_valid. lat counts rising edges after the accept edge.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, output int lat, output bit timed_out);
    bus.a        = ia;
    bus.b        = ib;
    bus.sub      = isub;
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    timed_out = !bus.out_valid;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.carry_out, bus.overflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready/out_valid/carry_out/overflow=%b required 1000",
               {bus.in_ready, bus.out_valid, bus.carry_out, bus.overflow});
    end
    n_checks++;
    if (bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_result: got %h required 00000000", bus.result);
    end
`ifdef ZERO_FLAG_EN
    n_checks++;
    if (bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_zero: got %b required 0", bus.zero);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_add();
    int lat;
    bit to;
    bus.out_ready = 1'b1;
    // T1: 1 + FFFFFFFF wraps to 0 with carry out.
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL t1_timeout: out_valid never rose");
    end
    // Accept cycle itself counted, then NSL slice cycles.
    n_checks++;
    if (lat + 1 !== 5) begin
      n_fail++;
      $display("FAIL t1_latency: got %0d cycles required 5", lat + 1);
    end
    n_checks++;
    if ({bus.result, bus.carry_out, bus.overflow} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL t1_add: result=%h c=%b v=%b required 00000000 c=1 v=0",
               bus.result, bus.carry_out, bus.overflow);
    end
`ifdef ZERO_FLAG_EN
    n_checks++;
    if (bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_zero: got %b required 1", bus.zero);
    end
`endif
    @(negedge clock);
    // T2: carry ripples through all four slices into the sign bit.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, to);
    n_checks++;
    if (to || {bus.result, bus.carry_out, bus.overflow} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL t2_add: result=%h c=%b v=%b required 80000000 c=0 v=1",
               bus.result, bus.carry_out, bus.overflow);
    end
`ifdef ZERO_FLAG_EN
    n_checks++;
    if (bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_zero: got %b required 0", bus.zero);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_sub();
    int lat;
    bit to;
    bus.out_ready = 1'b1;
    run_op(32'd5, 32'd7, 1'b1, lat, to);
    n_checks++;
    if (to || {bus.result, bus.carry_out, bus.overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL t3_sub_borrow: result=%h c=%b v=%b required FFFFFFFE c=0 v=0",
               bus.result, bus.carry_out, bus.overflow);
    end
    @(negedge clock);
    run_op(32'h8000_0000, 32'd1, 1'b1, lat, to);
    n_checks++;
    if (to || {bus.result, bus.carry_out, bus.overflow} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL t3_sub_ovf: result=%h c=%b v=%b required 7FFFFFFF c=1 v=1",
               bus.result, bus.carry_out, bus.overflow);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    bus.out_ready = 1'b0;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL t4_timeout: out_valid never rose");
    end
    for (int i = 0; i < 10; i++) begin
      // A competing request must be ignored while the result is pending.
      bus.in_valid = 1'b1;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h0000_0001;
      bus.sub      = 1'b1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.carry_out, bus.overflow} !==
          {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL t4_hold[%0d]: ov=%b ir=%b result=%h c=%b v=%b required ov=1 ir=0 00000100 c=0 v=0",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.carry_out, bus.overflow);
      end
      @(negedge clock);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, 32'h0000_0100}) begin
      n_fail++;
      $display("FAIL t4_release: ov=%b ir=%b result=%h required ov=0 ir=1 00000100",
               bus.out_valid, bus.in_ready, bus.result);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit to;
    bus.out_ready = 1'b1;
    bus.a         = 32'h0101_0101;
    bus.b         = 32'h0101_0101;
    bus.sub       = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clock);            // accept
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(posedge clock);            // slice 0 written
    @(negedge clock);
    reset = 1'b1;                // second RUN cycle
    @(negedge clock);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL t5_reset: ov=%b ir=%b result=%h required ov=0 ir=1 00000000",
               bus.out_valid, bus.in_ready, bus.result);
    end
    reset = 1'b0;
    @(negedge clock);
    run_op(32'h0000_00FF, 32'h0000_0F01, 1'b0, lat, to);
    n_checks++;
    if (to || {bus.result, bus.carry_out, bus.overflow} !== {32'h0000_1000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL t5_after: result=%h c=%b v=%b required 00001000 c=0 v=0",
               bus.result, bus.carry_out, bus.overflow);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vs [3];
    logic [33:0] ex [3];         // {result, carry_out, overflow}
    int idx;
    int ridx;
    int last_acc;
    va = '{32'h1234_5678, 32'h0000_0010, 32'h8000_0000};
    vb = '{32'h1111_1111, 32'h0000_0020, 32'h8000_0001};
    vs = '{1'b0, 1'b1, 1'b0};
    ex = '{{32'h2345_6789, 1'b0, 1'b0},
           {32'hFFFF_FFF0, 1'b0, 1'b0},
           {32'h0000_0001, 1'b1, 1'b1}};
    idx      = 0;
    ridx     = 0;
    last_acc = -1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 60 && ridx < 3; cyc++) begin
      if (bus.out_valid) begin
        n_checks++;
        if ({bus.result, bus.carry_out, bus.overflow} !== ex[ridx]) begin
          n_fail++;
          $display("FAIL t6_result[%0d]: got %h/%b/%b required %h/%b/%b", ridx,
                   bus.result, bus.carry_out, bus.overflow,
                   ex[ridx][33:2], ex[ridx][1], ex[ridx][0]);
        end
`ifdef ZERO_FLAG_EN
        n_checks++;
        if (bus.zero !== 1'b0) begin
          n_fail++;
          $display("FAIL t6_zero[%0d]: got %b required 0", ridx, bus.zero);
        end
`endif
        ridx++;
      end
      if (bus.in_ready) begin
        if (idx < 3) begin
          bus.a   = va[idx];
          bus.b   = vb[idx];
          bus.sub = vs[idx];
          if (last_acc >= 0) begin
            n_checks++;
            if (cyc - last_acc !== 6) begin
              n_fail++;
              $display("FAIL t6_spacing[%0d]: got %0d cycles required 6", idx, cyc - last_acc);
            end
          end
          last_acc = cyc;
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (ridx !== 3) begin
      n_fail++;
      $display("FAIL t6_count: got %0d results required 3", ridx);
    end
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    @(negedge clock);
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
